trace_nop_event_monitor: RTL

Per-core consumer of the unpacked execution trace: watches retired instructions for OR1K `l.nop K` simulation-control opcodes and turns them into timestamped events.
- Inputs: one core's trace fields plus the architectural r3 value maintained by `r3_checker`.
- Events (exit, report, putc) are queued in a small FIFO and drained over a valid/ready port by a system-level collector.
- Also tracks retired-instruction count, halt state and exit code.
- One instance per core, alongside each `r3_checker` in the per-core generate loop.

---
 rtl/trace_monitor_pkg.sv | 23 ++
 rtl/trace_event_fifo.sv | 47 ++++
 rtl/trace_nop_event_monitor.sv | 97 +++++++++
 3 files changed

// File: rtl/trace_monitor_pkg.sv
// trace_monitor_pkg: shared event types, l.nop constants and the packed event record
package trace_monitor_pkg;

    typedef enum logic [1:0] {
        EV_NONE   = 2'd0,
        EV_EXIT   = 2'd1,
        EV_REPORT = 2'd2,
        EV_PUTC   = 2'd3
    } ev_type_e;

    localparam logic [15:0] NOP_OPCODE_HI = 16'h1500;
    localparam logic [15:0] NOP_K_EXIT    = 16'h0001;
    localparam logic [15:0] NOP_K_REPORT  = 16'h0002;
    localparam logic [15:0] NOP_K_PUTC    = 16'h0004;

    typedef struct packed {
        ev_type_e    ev_type;
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] timestamp;
    } trace_event_t;

endpackage

// File: rtl/trace_event_fifo.sv
// trace_event_fifo: sync FIFO of trace events; a push into a full FIFO succeeds only alongside a pop
module trace_event_fifo
    import trace_monitor_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  trace_event_t data_i,
    input  logic         pop_i,
    output trace_event_t head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    trace_event_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic push_ok, pop_ok;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    // Head reads as zero when empty so idle outputs match their reset values.
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/trace_nop_event_monitor.sv
// trace_nop_event_monitor: turns retired l.nop K simulation-control opcodes into timestamped events
module trace_nop_event_monitor
    import trace_monitor_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CORE_ID    = 0
) (
    input  logic        clk,
    input  logic        rst_sys,
    input  logic        trace_valid,
    input  logic [31:0] trace_insn,
    input  logic [31:0] trace_pc,
    input  logic [31:0] r3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_type,
    output logic [31:0] out_data,
    output logic [31:0] out_pc,
    output logic [31:0] out_timestamp,
    output logic [7:0]  out_core,
    output logic        halted,
    output logic [31:0] exit_code,
    output logic [31:0] insn_count,
    output logic        overflow,
    output logic [15:0] drop_count
);
    logic [31:0] cyc_q, insn_count_q, exit_code_q;
    logic [15:0] drop_q;
    logic halted_q, overflow_q;
    logic is_nop, push, pop, full, empty, drop;
    ev_type_e kind;
    trace_event_t ev, head;

    assign is_nop = trace_valid && trace_insn[31:16] == NOP_OPCODE_HI && !halted_q;

    always_comb begin
        kind = !is_nop                         ? EV_NONE   :
               trace_insn[15:0] == NOP_K_EXIT   ? EV_EXIT   :
               trace_insn[15:0] == NOP_K_REPORT ? EV_REPORT :
               trace_insn[15:0] == NOP_K_PUTC   ? EV_PUTC   : EV_NONE;
        ev.ev_type   = kind;
        ev.data      = kind == EV_PUTC ? {24'h0, r3[7:0]} : r3;
        ev.pc        = trace_pc;
        ev.timestamp = cyc_q;
    end

    assign push = kind != EV_NONE;
    assign pop  = out_valid && out_ready;
    assign drop = push && full && !pop;

    trace_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst_sys),
        .push_i  (push),
        .data_i  (ev),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (rst_sys) begin
            cyc_q        <= '0;
            insn_count_q <= '0;
            exit_code_q  <= '0;
            halted_q     <= 1'b0;
            overflow_q   <= 1'b0;
            drop_q       <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (trace_valid && !halted_q) insn_count_q <= insn_count_q + 32'd1;
            // Halt is recorded even when the EXIT event itself is dropped.
            if (kind == EV_EXIT) begin
                halted_q    <= 1'b1;
                exit_code_q <= r3;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                drop_q     <= drop_q + 16'(drop_q != 16'hFFFF);
            end
        end
    end

    assign out_valid     = !empty;
    assign out_type      = head.ev_type;
    assign out_data      = head.data;
    assign out_pc        = head.pc;
    assign out_timestamp = head.timestamp;
    assign out_core      = 8'(CORE_ID);
    assign halted        = halted_q;
    assign exit_code     = exit_code_q;
    assign insn_count    = insn_count_q;
    assign overflow      = overflow_q;
    assign drop_count    = drop_q;

endmodule
